// File: rtl/obi_bus_interconnect.sv
// OBI crossbar: address decode, per-slave fixed-priority arbitration (master 0 highest), parallel slaves.
// Latency: grant same cycle, rvalid/rdata one cycle later; backpressure: losers see gnt=0 and hold their request.
module obi_bus_interconnect #(
  parameter int MASTERS = 3,
  parameter int SLAVES  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MASTERS-1:0]       master_req_i,
  output logic [MASTERS-1:0]       master_gnt_o,
  output logic [MASTERS-1:0]       master_rvalid_o,
  input  logic [MASTERS-1:0]       master_we_i,
  input  logic [MASTERS-1:0][3:0]  master_be_i,
  input  logic [MASTERS-1:0][31:0] master_addr_i,
  input  logic [MASTERS-1:0][31:0] master_wdata_i,
  output logic [MASTERS-1:0][31:0] master_rdata_o,
  input  logic [SLAVES-1:0][31:0]  slave_addr_mask_i,
  input  logic [SLAVES-1:0][31:0]  slave_addr_base_i,
  output logic [SLAVES-1:0]        slave_req_o,
  input  logic [SLAVES-1:0]        slave_gnt_i,
  input  logic [SLAVES-1:0]        slave_rvalid_i,
  output logic [SLAVES-1:0]        slave_we_o,
  output logic [SLAVES-1:0][3:0]   slave_be_o,
  output logic [SLAVES-1:0][31:0]  slave_addr_o,
  output logic [SLAVES-1:0][31:0]  slave_wdata_o,
  input  logic [SLAVES-1:0][31:0]  slave_rdata_i
);

  // Slave index width; the value SLAVES encodes "unmapped".
  localparam int IW = $clog2(SLAVES + 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  obi_req_t [MASTERS-1:0]      mreq;
  obi_req_t [SLAVES-1:0]       fwd;
  logic [MASTERS-1:0][IW-1:0]  tgt;
  logic [MASTERS-1:0][IW-1:0]  sidx;
  logic [MASTERS-1:0]          pend;
  logic                        unused_slave_hs;

  assign unused_slave_hs = ^{slave_gnt_i, slave_rvalid_i};

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      mreq[m] = '{we: master_we_i[m], be: master_be_i[m],
                  addr: master_addr_i[m], wdata: master_wdata_i[m]};
    end
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      tgt[m] = IW'(SLAVES);
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((master_addr_i[m] & slave_addr_mask_i[s]) == slave_addr_base_i[s]) begin
          tgt[m] = IW'(s);
        end
      end
    end
  end

  always_comb begin
    logic hit;
    hit          = 1'b0;
    master_gnt_o = '0;
    slave_req_o  = '0;
    fwd          = '0;
    for (int s = 0; s < SLAVES; s++) begin
      hit = 1'b0;
      for (int m = 0; m < MASTERS; m++) begin
        if (!hit && master_req_i[m] && tgt[m] == IW'(s)) begin
          hit             = 1'b1;
          master_gnt_o[m] = 1'b1;
          slave_req_o[s]  = 1'b1;
          fwd[s]          = mreq[m];
        end
      end
    end
    // Unmapped accesses are accepted at once and never reach a slave.
    for (int m = 0; m < MASTERS; m++) begin
      if (master_req_i[m] && tgt[m] == IW'(SLAVES)) begin
        master_gnt_o[m] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      slave_we_o[s]    = fwd[s].we;
      slave_be_o[s]    = fwd[s].be;
      slave_addr_o[s]  = fwd[s].addr;
      slave_wdata_o[s] = fwd[s].wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
    end else begin
      pend <= master_gnt_o;
    end
    sidx <= tgt;
  end

  assign master_rvalid_o = pend;

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      master_rdata_o[m] = '0;
      if (pend[m]) begin
        for (int s = 0; s < SLAVES; s++) begin
          if (sidx[m] == IW'(s)) begin
            master_rdata_o[m] = slave_rdata_i[s];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_obi_bus_interconnect.sv
// Vector-table bench for obi_bus_interconnect with a one-cycle response scoreboard.
module tb_obi_bus_interconnect;

  localparam int M = 3;
  localparam int S = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [M-1:0]        m_req, m_gnt, m_rvalid, m_we;
  logic [M-1:0][3:0]   m_be;
  logic [M-1:0][31:0]  m_addr, m_wdata, m_rdata;
  logic [S-1:0][31:0]  s_mask, s_base, s_rdata;
  logic [S-1:0]        s_req, s_gnt, s_rvalid, s_we;
  logic [S-1:0][3:0]   s_be;
  logic [S-1:0][31:0]  s_addr, s_wdata;

  obi_bus_interconnect #(.MASTERS(M), .SLAVES(S)) dut (
    .clk_i(clk), .rst_i(rst),
    .master_req_i(m_req), .master_gnt_o(m_gnt), .master_rvalid_o(m_rvalid),
    .master_we_i(m_we), .master_be_i(m_be), .master_addr_i(m_addr),
    .master_wdata_i(m_wdata), .master_rdata_o(m_rdata),
    .slave_addr_mask_i(s_mask), .slave_addr_base_i(s_base),
    .slave_req_o(s_req), .slave_gnt_i(s_gnt), .slave_rvalid_i(s_rvalid),
    .slave_we_o(s_we), .slave_be_o(s_be), .slave_addr_o(s_addr),
    .slave_wdata_o(s_wdata), .slave_rdata_i(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               rst;
    logic [M-1:0]       req;
    logic [M-1:0]       we;
    logic [M-1:0][3:0]  be;
    logic [M-1:0][31:0] addr;
    logic [M-1:0][31:0] wdata;
    logic [M-1:0]       exp_gnt;
    logic [S-1:0]       exp_sreq;
  } vec_t;

  typedef struct packed {
    logic [M-1:0]       rv;
    logic [M-1:0][31:0] rd;
  } rsp_t;

  vec_t vt[$];
  rsp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference decode for the fixed test map; 3 means unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < S; s++) begin
      if ((a & 32'hF000_0000) == (32'h1000_0000 * s)) return s;
    end
    return S;
  endfunction

  function automatic logic [31:0] srd(input int s);
    case (s)
      0:       return 32'h1234_5678;
      1:       return 32'h5555_1111;
      2:       return 32'h2222_AAAA;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic [2:0] req, input logic [2:0] we,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [2:0] eg, input logic [2:0] es);
    vec_t v;
    v.rst = r; v.req = req; v.we = we;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.be[0] = be0; v.be[1] = 4'hF; v.be[2] = 4'hF;
    v.wdata[0] = wd0; v.wdata[1] = 32'hC0DE_0001; v.wdata[2] = 32'hC0DE_0002;
    v.exp_gnt = eg; v.exp_sreq = es;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rsp_t e;
    int   w;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int m = 0; m < M; m++) begin
        chk($sformatf("%s rvalid%0d", tag, m), 32'(m_rvalid[m]), 32'(e.rv[m]));
        chk($sformatf("%s rdata%0d", tag, m), m_rdata[m], e.rd[m]);
      end
    end
    rst = v.rst; m_req = v.req; m_we = v.we; m_be = v.be;
    m_addr = v.addr; m_wdata = v.wdata;
    #1;
    chk($sformatf("%s gnt", tag), 32'(m_gnt), 32'(v.exp_gnt));
    chk($sformatf("%s slave_req", tag), 32'(s_req), 32'(v.exp_sreq));
    for (int s = 0; s < S; s++) begin
      w = -1;
      for (int m = M - 1; m >= 0; m--) begin
        if (v.exp_gnt[m] && decode(v.addr[m]) == s) w = m;
      end
      if (w >= 0) begin
        chk($sformatf("%s s%0d addr", tag, s), s_addr[s], v.addr[w]);
        chk($sformatf("%s s%0d we_be", tag, s), {27'h0, s_we[s], s_be[s]}, {27'h0, v.we[w], v.be[w]});
        chk($sformatf("%s s%0d wdata", tag, s), s_wdata[s], v.wdata[w]);
      end else begin
        chk($sformatf("%s s%0d idle", tag, s), s_addr[s] | s_wdata[s] | {27'h0, s_we[s], s_be[s]}, 32'h0);
      end
    end
    e = '0;
    if (!v.rst) begin
      for (int m = 0; m < M; m++) begin
        e.rv[m] = v.exp_gnt[m];
        e.rd[m] = v.exp_gnt[m] ? srd(decode(v.addr[m])) : 32'h0;
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0;
    for (int s = 0; s < S; s++) begin
      s_mask[s]  = 32'hF000_0000;
      s_base[s]  = 32'h1000_0000 * s;
      s_rdata[s] = srd(s);
    end

    vt.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));
    vt.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));
    vt.push_back(mk(0, 3'b100, 3'b000, 0, 0, 32'h0000_0010, 4'hF, 0, 3'b100, 3'b001));
    vt.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));
    vt.push_back(mk(0, 3'b101, 3'b000, 32'h1000_0004, 0, 32'h1000_0004, 4'hF, 0, 3'b001, 3'b010));
    vt.push_back(mk(0, 3'b100, 3'b000, 32'h1000_0004, 0, 32'h1000_0004, 4'hF, 0, 3'b100, 3'b010));
    vt.push_back(mk(0, 3'b101, 3'b001, 32'h1000_0000, 0, 0, 4'h3, 32'hDEAD_BEEF, 3'b101, 3'b011));
    vt.push_back(mk(0, 3'b010, 3'b000, 0, 32'h8000_0000, 0, 4'hF, 0, 3'b010, 3'b000));
    vt.push_back(mk(0, 3'b111, 3'b000, 32'h2000_0008, 32'h4, 32'h1000_000C, 4'hF, 0, 3'b111, 3'b111));
    vt.push_back(mk(0, 3'b111, 3'b000, 0, 32'h4, 32'h8, 4'hF, 0, 3'b001, 3'b001));
    vt.push_back(mk(0, 3'b110, 3'b000, 0, 32'h4, 32'h8, 4'hF, 0, 3'b010, 3'b001));
    vt.push_back(mk(0, 3'b101, 3'b001, 32'hF000_0000, 32'h4, 32'h8, 4'hF, 32'h1111, 3'b101, 3'b001));
    vt.push_back(mk(0, 3'b100, 3'b000, 0, 0, 32'hC, 4'hF, 0, 3'b100, 3'b001));
    vt.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));
    vt.push_back(mk(0, 3'b001, 3'b000, 32'h1000_0000, 0, 0, 4'hF, 0, 3'b001, 3'b010));
    vt.push_back(mk(1, 3'b010, 3'b000, 0, 32'h2000_0000, 0, 4'hF, 0, 3'b010, 3'b100));
    vt.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));
    vt.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("v%0d", i));

    // Master 2 starves behind master 0 on slave 2, then wins once master 0 drops.
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 3'b101, 3'b000, 32'h2000_0000 + 4 * i, 0, 32'h2000_0040, 4'hF, 0, 3'b001, 3'b100),
            $sformatf("starve%0d", i));
    end
    apply(mk(0, 3'b100, 3'b000, 0, 0, 32'h2000_0040, 4'hF, 0, 3'b100, 3'b100), "starve_end");
    apply(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000), "drain0");
    apply(mk(0, 3'b000, 3'b000, 0, 0, 0, 4'hF, 0, 3'b000, 3'b000), "drain1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
